dma_transfer_engine: RTL and testbench
======================================

// Module: dma_transfer_engine
// PURPOSE
//  Sequences memory-to-memory copies programmed through the AXI-lite register block.
//  It consumes start/irq_enable/src_addr/dst_addr/length and returns busy/done to the status register.
//  It moves one REG_WIDTH word at a time over separate request/grant/response read and write ports.
//  It raises an interrupt on completion and a watchdog error if a response never arrives.
// PARAMETERS
//  REG_WIDTH       32    data/address/length width; word = REG_WIDTH/8 bytes (power of 2)
//  TIMEOUT_CYCLES  1024  max cycles waiting in any *_WAIT state before abort (>=2)
// PORTS
//  ACLK        in   1          clock, all logic on rising edge
//  ARESETn     in   1          asynchronous active-low reset
//  start       in   1          one-cycle start pulse from register block
//  irq_enable  in   1          enables irq on completion/abort
//  src_addr    in   REG_WIDTH  source byte address (word aligned; low bits ignored)
//  dst_addr    in   REG_WIDTH  destination byte address (word aligned; low bits ignored)
//  length      in   REG_WIDTH  byte count; words = length >> log2(REG_WIDTH/8), remainder dropped
//  busy        out  1          transfer in progress
//  done        out  1          sticky: last transfer finished (ok or error)
//  error       out  1          sticky: last transfer aborted (rd_err, wr_err or timeout)
//  irq         out  1          one-cycle pulse at completion when irq_enable=1
//  rd_req      out  1          read request, held until rd_gnt
//  rd_addr     out  REG_WIDTH  read word address (byte address, low bits 0)
//  rd_gnt      in   1          read request accepted this cycle
//  rd_valid    in   1          read data returned
//  rd_data     in   REG_WIDTH  read data, sampled when rd_valid=1
//  rd_err      in   1          read error, qualified by rd_valid
//  wr_req      out  1          write request, held until wr_gnt
//  wr_addr     out  REG_WIDTH  write word address
//  wr_data     out  REG_WIDTH  write data (captured rd_data), stable while wr_req=1
//  wr_gnt      in   1          write request accepted this cycle
//  wr_ack      in   1          write completion
//  wr_err      in   1          write error, qualified by wr_ack
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, error, irq, rd_req, wr_req = 0; rd_addr, wr_addr, wr_data,
//    word counter and timeout counter = 0.
//  FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
//  IDLE:
//    start=1 latches src, dst and word count; clears done and error.
//    If word count != 0, go to RD_REQ next cycle (busy and rd_req high at N+1).
//    If word count == 0, go to FINISH directly (no memory traffic).
//  RD_REQ: rd_req=1; on rd_gnt go to RD_WAIT.
//  RD_WAIT:
//    on rd_valid & !rd_err, capture rd_data into wr_data and go to WR_REQ;
//    on rd_valid & rd_err, set error and go to FINISH.
//  WR_REQ: wr_req=1; on wr_gnt go to WR_WAIT.
//  WR_WAIT: on wr_ack & wr_err, set error and go to FINISH; on wr_ack & !wr_err:
//    add word bytes to both addresses (modulo 2^REG_WIDTH, wraps silently) and decrement the count;
//    if count was 1, go to FINISH, else go to RD_REQ.
//  FINISH (1 cycle): busy=0, done<=1, irq=irq_enable; go to IDLE.
//  Timing:
//    busy=1 in every state except IDLE/FINISH; min 4 cycles per word (gnt and resp same-cycle-after).
//  Timeout: counter clears on entry to RD_WAIT/WR_WAIT and increments each cycle in the state.
//    Reaching TIMEOUT_CYCLES with no response sets error and goes to FINISH.
//  rd_valid/wr_ack outside their WAIT state are ignored; start while busy or in FINISH is ignored.
//  Simultaneous gnt and response in the same cycle: only gnt is honoured; response expected later.
//  Async reset mid-transfer: immediate return to reset values; no partial state retained.
// TESTING
//  1) src=0x100, dst=0x200, length=16, 1-cycle gnt/resp
//     -> 4 reads then 4 writes at 0x100..0x10C -> 0x200..0x20C, data matched;
//     -> done=1, error=0, busy low after FINISH.
//  2) length=0, irq_enable=1, start
//     -> no rd_req/wr_req; FINISH 1 cycle after start; irq one-cycle pulse; done=1.
//  3) length=8, rd_err on second read
//     -> exactly 1 write issued; error=1, done=1; irq only if irq_enable.
//  4) TIMEOUT_CYCLES=8, rd_valid never returned
//     -> abort after 8 cycles in RD_WAIT; error=1; next start clears error and completes normally.
//  5) src=0xFFFF_FFFC, length=8
//     -> read addresses 0xFFFF_FFFC then 0x0000_0000; start pulses while busy have no effect.
//  6) ARESETn low during WR_WAIT
//     -> all outputs 0 same cycle; after release, new start copies correctly.

Source files
------------

// File: rtl/dma_transfer_engine_if.sv
// Register-block control/status and memory read/write request/grant/response ports of the DMA engine.
// "master" is the engine side; "slave" is the register block plus memory side.
interface dma_transfer_engine_if #(
  parameter int REG_WIDTH = 32
);
  logic                 start;
  logic                 irq_enable;
  logic [REG_WIDTH-1:0] src_addr;
  logic [REG_WIDTH-1:0] dst_addr;
  logic [REG_WIDTH-1:0] length;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 irq;
  logic                 rd_req;
  logic [REG_WIDTH-1:0] rd_addr;
  logic                 rd_gnt;
  logic                 rd_valid;
  logic [REG_WIDTH-1:0] rd_data;
  logic                 rd_err;
  logic                 wr_req;
  logic [REG_WIDTH-1:0] wr_addr;
  logic [REG_WIDTH-1:0] wr_data;
  logic                 wr_gnt;
  logic                 wr_ack;
  logic                 wr_err;

  modport master (
    input  start, irq_enable, src_addr, dst_addr, length,
    input  rd_gnt, rd_valid, rd_data, rd_err, wr_gnt, wr_ack, wr_err,
    output busy, done, error, irq, rd_req, rd_addr, wr_req, wr_addr, wr_data
  );
  modport slave (
    output start, irq_enable, src_addr, dst_addr, length,
    output rd_gnt, rd_valid, rd_data, rd_err, wr_gnt, wr_ack, wr_err,
    input  busy, done, error, irq, rd_req, rd_addr, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/dma_transfer_engine.sv
// Word-at-a-time memory-to-memory copy engine: read a word, write it, advance, repeat.
// Aborts on a read/write error or when a response takes TIMEOUT_CYCLES cycles.
module dma_transfer_engine #(
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  dma_transfer_engine_if.master bus
);
  localparam int WB = REG_WIDTH / 8;
  localparam int SH = $clog2(WB);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [REG_WIDTH-1:0] AMASK    = ~REG_WIDTH'(WB - 1);
  localparam logic [REG_WIDTH-1:0] WSTEP    = REG_WIDTH'(WB);
  localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_e;

  state_e               state_q;
  logic [REG_WIDTH-1:0] rd_addr_q, wr_addr_q, wr_data_q, cnt_q;
  logic [TW-1:0]        tmo_q;
  logic                 busy_q, done_q, error_q, irq_q, rd_req_q, wr_req_q;
  logic [REG_WIDTH-1:0] words;
  logic                 tmo_hit;

  assign words   = bus.length >> SH;
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      irq_q     <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          rd_addr_q <= bus.src_addr & AMASK;
          wr_addr_q <= bus.dst_addr & AMASK;
          cnt_q     <= words;
          error_q   <= 1'b0;
          if (words != '0) begin
            state_q  <= RD_REQ;
            busy_q   <= 1'b1;
            rd_req_q <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            irq_q   <= bus.irq_enable;
          end
        end
        // A response arriving together with the grant is not seen here; only the grant counts.
        RD_REQ: if (bus.rd_gnt) begin
          rd_req_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.rd_valid && !bus.rd_err) begin
            wr_data_q <= bus.rd_data;
            wr_req_q  <= 1'b1;
            state_q   <= WR_REQ;
          end else if (bus.rd_valid || tmo_hit) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            irq_q   <= bus.irq_enable;
            state_q <= FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        WR_REQ: if (bus.wr_gnt) begin
          wr_req_q <= 1'b0;
          tmo_q    <= '0;
          state_q  <= WR_WAIT;
        end
        WR_WAIT: begin
          if (bus.wr_ack && !bus.wr_err) begin
            rd_addr_q <= rd_addr_q + WSTEP;
            wr_addr_q <= wr_addr_q + WSTEP;
            cnt_q     <= cnt_q - REG_WIDTH'(1);
            if (cnt_q == REG_WIDTH'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              irq_q   <= bus.irq_enable;
              state_q <= FINISH;
            end else begin
              rd_req_q <= 1'b1;
              state_q  <= RD_REQ;
            end
          end else if (bus.wr_ack || tmo_hit) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            done_q  <= 1'b1;
            irq_q   <= bus.irq_enable;
            state_q <= FINISH;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
  assign bus.irq     = irq_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_req  = wr_req_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_dma_transfer_engine.sv
// Directed bench for dma_transfer_engine: a per-cycle memory responder plus one task per scenario.
module tb_dma_transfer_engine;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  dma_transfer_engine_if #(.REG_WIDTH(32)) bus ();
  dma_transfer_engine #(.REG_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus.master));

  int total = 0;
  int bad = 0;

  logic [31:0] rd_q[$], wra_q[$], wrd_q[$];
  int irq_cnt, traffic, fin_it, gnt_it;
  bit timed_out;
  logic [5:0]  snap_ctl;
  logic [31:0] snap_bus;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_1111;
  endfunction

  task automatic idle_inputs();
    bus.start = 0; bus.rd_gnt = 0; bus.rd_valid = 0; bus.rd_data = '0; bus.rd_err = 0;
    bus.wr_gnt = 0; bus.wr_ack = 0; bus.wr_err = 0;
  endtask

  // Runs one transfer with a 1-cycle grant/response memory; records traffic for the caller to check.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                          input bit ie, input int rd_err_idx, input bit no_rdvalid,
                          input bit spam, input bit rst_wr);
    bit rd_pend, wr_pend;
    logic [31:0] pend_a;
    int nrd;
    rd_q.delete(); wra_q.delete(); wrd_q.delete();
    irq_cnt = 0; traffic = 0; fin_it = -1; gnt_it = -1; timed_out = 0;
    rd_pend = 0; wr_pend = 0; nrd = 0; pend_a = '0;
    @(negedge ACLK);
    bus.src_addr = s; bus.dst_addr = d; bus.length = l; bus.irq_enable = ie; bus.start = 1;
    for (int it = 1; it <= 300; it++) begin
      @(negedge ACLK);
      idle_inputs();
      if (bus.irq) irq_cnt++;
      if (bus.rd_req || bus.wr_req) traffic++;
      if (spam && bus.busy) begin bus.start = 1; bus.src_addr = 32'h5000; end
      if (fin_it >= 0) return;
      if (bus.done && !bus.busy) begin fin_it = it; continue; end
      if (rd_pend) begin
        rd_pend = 0;
        if (!no_rdvalid) begin
          bus.rd_valid = 1; bus.rd_data = mem(pend_a); bus.rd_err = (nrd == rd_err_idx);
          nrd++;
        end
      end else if (bus.rd_req) begin
        bus.rd_gnt = 1; rd_q.push_back(bus.rd_addr); pend_a = bus.rd_addr; rd_pend = 1; gnt_it = it;
      end else if (wr_pend) begin
        wr_pend = 0;
        if (rst_wr) begin
          ARESETn = 0;
          #1;
          snap_ctl = {bus.busy, bus.done, bus.error, bus.irq, bus.rd_req, bus.wr_req};
          snap_bus = bus.rd_addr | bus.wr_addr | bus.wr_data;
          return;
        end
        bus.wr_ack = 1;
      end else if (bus.wr_req) begin
        bus.wr_gnt = 1; wra_q.push_back(bus.wr_addr); wrd_q.push_back(bus.wr_data); wr_pend = 1;
      end
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    idle_inputs(); bus.irq_enable = 0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    total++;
    if ({bus.busy, bus.done, bus.error, bus.irq, bus.rd_req, bus.wr_req} !== 6'b0) begin
      bad++; $display("FAIL reset_ctl got=%b exp=000000",
        {bus.busy, bus.done, bus.error, bus.irq, bus.rd_req, bus.wr_req});
    end
    total++;
    if ((bus.rd_addr | bus.wr_addr | bus.wr_data) !== 32'h0) begin
      bad++; $display("FAIL reset_bus got=%h exp=0", bus.rd_addr | bus.wr_addr | bus.wr_data);
    end
    ARESETn = 1;
  endtask

  task automatic test_copy();
    run_xfer(32'h100, 32'h200, 32'd16, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    total++; if (timed_out) begin bad++; $display("FAIL copy_timeout got=stuck exp=finish"); end
    total++;
    if (rd_q.size() != 4 || wra_q.size() != 4) begin
      bad++; $display("FAIL copy_count got=%0d/%0d exp=4/4", rd_q.size(), wra_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rd_q[i] !== 32'h100 + 4*i || wra_q[i] !== 32'h200 + 4*i || wrd_q[i] !== mem(32'h100 + 4*i)) begin
          bad++; $display("FAIL copy_word%0d got=%h/%h/%h exp=%h/%h/%h", i, rd_q[i], wra_q[i], wrd_q[i],
            32'h100 + 4*i, 32'h200 + 4*i, mem(32'h100 + 4*i));
        end
      end
    end
    total++;
    if (fin_it != 17) begin bad++; $display("FAIL copy_latency got=%0d exp=17", fin_it); end
    total++;
    if ({bus.done, bus.error, bus.busy, irq_cnt[0]} !== 4'b1000) begin
      bad++; $display("FAIL copy_status got=%b exp=1000", {bus.done, bus.error, bus.busy, irq_cnt[0]});
    end
  endtask

  task automatic test_zero_len();
    run_xfer(32'h100, 32'h200, 32'd3, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    total++;
    if (fin_it != 1 || traffic != 0) begin
      bad++; $display("FAIL zero_len got=fin%0d/traffic%0d exp=fin1/traffic0", fin_it, traffic);
    end
    total++;
    if (irq_cnt != 1 || bus.done !== 1'b1 || bus.error !== 1'b0) begin
      bad++; $display("FAIL zero_status got=irq%0d/d%b/e%b exp=irq1/d1/e0", irq_cnt, bus.done, bus.error);
    end
  endtask

  task automatic test_rd_err();
    run_xfer(32'h800, 32'h900, 32'd8, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    total++;
    if (wra_q.size() != 1 || rd_q.size() != 2) begin
      bad++; $display("FAIL rderr_count got=w%0d/r%0d exp=w1/r2", wra_q.size(), rd_q.size());
    end
    total++;
    if ({bus.error, bus.done, bus.busy} !== 3'b110 || irq_cnt != 0) begin
      bad++; $display("FAIL rderr_status got=%b/irq%0d exp=110/irq0", {bus.error, bus.done, bus.busy}, irq_cnt);
    end
  endtask

  task automatic test_timeout();
    run_xfer(32'h40, 32'h80, 32'd4, 1'b1, -1, 1'b1, 1'b0, 1'b0);
    total++;
    if (fin_it - gnt_it != 9 || timed_out) begin
      bad++; $display("FAIL tmo_latency got=%0d exp=9", fin_it - gnt_it);
    end
    total++;
    if ({bus.error, bus.done} !== 2'b11 || wra_q.size() != 0 || irq_cnt != 1) begin
      bad++; $display("FAIL tmo_status got=%b/w%0d/irq%0d exp=11/w0/irq1", {bus.error, bus.done}, wra_q.size(), irq_cnt);
    end
    run_xfer(32'h40, 32'h80, 32'd4, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.error, bus.done} !== 2'b01 || wra_q.size() != 1 || wrd_q[0] !== mem(32'h40)) begin
      bad++; $display("FAIL tmo_recover got=%b/w%0d exp=01/w1", {bus.error, bus.done}, wra_q.size());
    end
  endtask

  task automatic test_wrap();
    run_xfer(32'hFFFF_FFFC, 32'h302, 32'd8, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    total++;
    if (rd_q.size() != 2 || wra_q.size() != 2) begin
      bad++; $display("FAIL wrap_count got=r%0d/w%0d exp=r2/w2", rd_q.size(), wra_q.size());
    end else begin
      total++;
      if (rd_q[0] !== 32'hFFFF_FFFC || rd_q[1] !== 32'h0) begin
        bad++; $display("FAIL wrap_rdaddr got=%h,%h exp=fffffffc,00000000", rd_q[0], rd_q[1]);
      end
      total++;
      if (wra_q[0] !== 32'h300 || wra_q[1] !== 32'h304 || wrd_q[1] !== mem(32'h0)) begin
        bad++; $display("FAIL wrap_wr got=%h,%h,%h exp=300,304,%h", wra_q[0], wra_q[1], wrd_q[1], mem(32'h0));
      end
    end
    total++;
    if (fin_it != 9 || bus.error !== 1'b0) begin
      bad++; $display("FAIL wrap_latency got=%0d/e%b exp=9/e0", fin_it, bus.error);
    end
  endtask

  task automatic test_reset_midflight();
    run_xfer(32'h600, 32'h700, 32'd8, 1'b1, -1, 1'b0, 1'b0, 1'b1);
    total++;
    if (snap_ctl !== 6'b0 || snap_bus !== 32'h0) begin
      bad++; $display("FAIL midreset got=%b/%h exp=000000/0", snap_ctl, snap_bus);
    end
    @(negedge ACLK);
    idle_inputs();
    ARESETn = 1;
    run_xfer(32'h400, 32'h500, 32'd12, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    total++;
    if (wra_q.size() != 3 || timed_out) begin
      bad++; $display("FAIL postreset_count got=%0d exp=3", wra_q.size());
    end else begin
      total++;
      if (wra_q[2] !== 32'h508 || wrd_q[2] !== mem(32'h408) || bus.done !== 1'b1) begin
        bad++; $display("FAIL postreset_data got=%h/%h exp=508/%h", wra_q[2], wrd_q[2], mem(32'h408));
      end
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zero_len();
    test_rd_err();
    test_timeout();
    test_wrap();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
